// File: rtl/combo_sequence_detector_if.sv
// Button/combo handshake bundle between the debounced input stage and the detector.
// master drives enable and buttons; slave (the detector) returns combo status.
interface combo_sequence_detector_if #(
    parameter int unsigned NUM_INPUTS = 6,
    parameter int unsigned STEP_W     = 3
);
    logic                  enable;
    logic [NUM_INPUTS-1:0] btn;
    logic                  window_open;
    logic [STEP_W-1:0]     step;
    logic                  combo_done;
    logic                  combo_fail;

    modport master (
        output enable, btn,
        input  window_open, step, combo_done, combo_fail
    );

    modport slave (
        input  enable, btn,
        output window_open, step, combo_done, combo_fail
    );
endinterface

// File: rtl/combo_sequence_detector.sv
// Recognises a fixed ordered button sequence where each press must follow the
// previous accepted press within WINDOW_CYCLES clocks; pulses done or fail.
module combo_sequence_detector #(
    parameter int unsigned               NUM_INPUTS    = 6,
    parameter int unsigned               IDX_W         = 3,
    parameter int unsigned               SEQ_LEN       = 3,
    parameter logic [SEQ_LEN*IDX_W-1:0]  COMBO_SEQ     = {3'd0, 3'd3, 3'd1},
    parameter int unsigned               WINDOW_CYCLES = 25000000,
    parameter int unsigned               CNT_W         = 25,
    parameter int unsigned               STEP_W        = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    combo_sequence_detector_if.slave    bus
);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

    typedef enum logic {ST_IDLE, ST_ARMED} state_t;

    state_t                r_state;
    logic [NUM_INPUTS-1:0] r_btn_q;
    logic [CNT_W-1:0]      r_timer;
    logic [STEP_W-1:0]     r_step;
    logic                  r_window_open;
    logic                  r_done;
    logic                  r_fail;

    logic [NUM_INPUTS-1:0] w_edge;
    logic                  w_onehot;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_exp;
    logic                  w_match0;
    logic                  w_match_cur;
    logic                  w_last;

    // Press decode: a match needs exactly one new rising edge on the expected line.
    always_comb begin
        w_edge   = bus.btn & ~r_btn_q;
        w_onehot = (w_edge != '0) && ((w_edge & (w_edge - NUM_INPUTS'(1))) == '0);
        w_idx    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_edge[i]) w_idx = IDX_W'(i);
        end
        w_exp = COMBO_SEQ[IDX_W-1:0];
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (r_step == STEP_W'(k)) w_exp = COMBO_SEQ[k*IDX_W +: IDX_W];
        end
        w_match0    = w_onehot && (w_idx == COMBO_SEQ[IDX_W-1:0]);
        w_match_cur = w_onehot && (w_idx == w_exp);
        w_last      = (r_step == LAST_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_btn_q       <= '1;
            r_timer       <= '0;
            r_step        <= '0;
            r_window_open <= 1'b0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_btn_q <= bus.btn;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            if (!bus.enable) begin
                r_state       <= ST_IDLE;
                r_timer       <= '0;
                r_step        <= '0;
                r_window_open <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_match0) begin
                            if (SEQ_LEN == 1) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state       <= ST_ARMED;
                                r_step        <= STEP_W'(1);
                                r_timer       <= RELOAD;
                                r_window_open <= 1'b1;
                            end
                        end
                    end
                    ST_ARMED: begin
                        if (w_match_cur) begin
                            if (w_last) begin
                                r_done        <= 1'b1;
                                r_state       <= ST_IDLE;
                                r_step        <= '0;
                                r_timer       <= '0;
                                r_window_open <= 1'b0;
                            end else begin
                                r_step  <= r_step + STEP_W'(1);
                                r_timer <= RELOAD;
                            end
                        end else if (w_edge != '0) begin
                            // A wrong press that is itself step 0 starts a fresh attempt.
                            r_fail <= 1'b1;
                            if (w_match0) begin
                                r_step  <= STEP_W'(1);
                                r_timer <= RELOAD;
                            end else begin
                                r_state       <= ST_IDLE;
                                r_step        <= '0;
                                r_timer       <= '0;
                                r_window_open <= 1'b0;
                            end
                        end else if (r_timer == '0) begin
                            r_fail        <= 1'b1;
                            r_state       <= ST_IDLE;
                            r_step        <= '0;
                            r_window_open <= 1'b0;
                        end else begin
                            r_timer <= r_timer - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_step        <= '0;
                        r_timer       <= '0;
                        r_window_open <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.window_open = r_window_open;
    assign bus.step        = r_step;
    assign bus.combo_done  = r_done;
    assign bus.combo_fail  = r_fail;
endmodule

// File: tb/tb_combo_sequence_detector.sv
// Bench for combo_sequence_detector: three instances (steps 1,3,0 / single step 2 /
// steps 2,2,5) share one button bus; a sequence-count model checks every cycle.
module tb_combo_sequence_detector;
    localparam int WIN = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] btn;

    int checks = 0;
    int errors = 0;

    combo_sequence_detector_if #(.NUM_INPUTS(6), .STEP_W(3)) if0 ();
    combo_sequence_detector_if #(.NUM_INPUTS(6), .STEP_W(3)) if1 ();
    combo_sequence_detector_if #(.NUM_INPUTS(6), .STEP_W(3)) if2 ();

    assign if0.enable = en;
    assign if1.enable = en;
    assign if2.enable = en;
    assign if0.btn    = btn;
    assign if1.btn    = btn;
    assign if2.btn    = btn;

    combo_sequence_detector #(
        .NUM_INPUTS(6), .IDX_W(3), .SEQ_LEN(3), .COMBO_SEQ({3'd0, 3'd3, 3'd1}),
        .WINDOW_CYCLES(WIN), .CNT_W(4), .STEP_W(3)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    combo_sequence_detector #(
        .NUM_INPUTS(6), .IDX_W(3), .SEQ_LEN(1), .COMBO_SEQ(3'd2),
        .WINDOW_CYCLES(WIN), .CNT_W(4), .STEP_W(3)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    combo_sequence_detector #(
        .NUM_INPUTS(6), .IDX_W(3), .SEQ_LEN(3), .COMBO_SEQ({3'd5, 3'd2, 3'd2}),
        .WINDOW_CYCLES(WIN), .CNT_W(4), .STEP_W(3)
    ) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [2:0] g_open, g_done, g_fail;
    logic [2:0] g_step [3];
    assign g_open    = {if2.window_open, if1.window_open, if0.window_open};
    assign g_done    = {if2.combo_done, if1.combo_done, if0.combo_done};
    assign g_fail    = {if2.combo_fail, if1.combo_fail, if0.combo_fail};
    assign g_step[0] = if0.step;
    assign g_step[1] = if1.step;
    assign g_step[2] = if2.step;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count of matched steps plus idle cycles since last accepted press.
    int         m_len [3];
    int         m_seq [3][3];
    int         m_count [3];
    int         m_age [3];
    logic       m_done [3];
    logic       m_fail [3];
    logic [5:0] m_prev;

    task automatic model_step(input logic r, input logic e, input logic [5:0] b);
        logic [5:0] edg;
        int         idx;
        logic       one;
        if (r) begin
            m_prev = '1;
            for (int d = 0; d < 3; d++) begin
                m_count[d] = 0; m_age[d] = 0; m_done[d] = 0; m_fail[d] = 0;
            end
            return;
        end
        edg    = b & ~m_prev;
        m_prev = b;
        one    = ($countones(edg) == 1);
        idx    = 0;
        for (int i = 0; i < 6; i++) if (edg[i]) idx = i;
        for (int d = 0; d < 3; d++) begin
            m_done[d] = 0;
            m_fail[d] = 0;
            if (!e) begin
                m_count[d] = 0;
            end else if (edg != 0) begin
                if (one && idx == m_seq[d][m_count[d]]) begin
                    m_count[d]++;
                    m_age[d] = 0;
                    if (m_count[d] == m_len[d]) begin
                        m_done[d]  = 1;
                        m_count[d] = 0;
                    end
                end else if (m_count[d] > 0) begin
                    m_fail[d] = 1;
                    m_age[d]  = 0;
                    m_count[d] = (one && idx == m_seq[d][0]) ? 1 : 0;
                end
            end else if (m_count[d] > 0) begin
                m_age[d]++;
                if (m_age[d] >= WIN) begin
                    m_fail[d]  = 1;
                    m_count[d] = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic tr, input logic te, input logic [5:0] tb);
        rst = tr; en = te; btn = tb;
        @(posedge clk);
        model_step(tr, te, tb);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (g_open[d] !== (m_count[d] > 0) || int'(g_step[d]) != m_count[d] ||
                g_done[d] !== m_done[d] || g_fail[d] !== m_fail[d]) begin
                errors++;
                $display("FAIL model dut%0d t=%0t: got open=%0b step=%0d done=%0b fail=%0b, expected open=%0b step=%0d done=%0b fail=%0b",
                         d, $time, g_open[d], g_step[d], g_done[d], g_fail[d],
                         (m_count[d] > 0), m_count[d], m_done[d], m_fail[d]);
            end
        end
    endtask

    task automatic expect4(input string name, input int d, input logic o, input int s,
                           input logic dn, input logic f);
        checks++;
        if (g_open[d] !== o || int'(g_step[d]) != s || g_done[d] !== dn || g_fail[d] !== f) begin
            errors++;
            $display("FAIL %s dut%0d: got open=%0b step=%0d done=%0b fail=%0b, expected open=%0b step=%0d done=%0b fail=%0b",
                     name, d, g_open[d], g_step[d], g_done[d], g_fail[d], o, s, dn, f);
        end
    endtask

    task automatic go_idle();
        tick(1'b0, 1'b0, 6'h00);
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [5:0] b;
        logic       o;
        int         s;
        logic       dn;
        logic       f;
    } vec_t;

    vec_t tbl [24];

    initial begin
        logic [5:0] b;
        int         sel;
        m_len[0] = 3; m_seq[0][0] = 1; m_seq[0][1] = 3; m_seq[0][2] = 0;
        m_len[1] = 1; m_seq[1][0] = 2; m_seq[1][1] = 0; m_seq[1][2] = 0;
        m_len[2] = 3; m_seq[2][0] = 2; m_seq[2][1] = 2; m_seq[2][2] = 5;
        m_prev = '1;
        for (int d = 0; d < 3; d++) begin
            m_count[d] = 0; m_age[d] = 0; m_done[d] = 0; m_fail[d] = 0;
        end

        // Nominal combo, wrong press, mid-combo reset, enable drop (dut0).
        tbl[0]  = '{1'b1, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 6'h02, 1'b1, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 6'h02, 1'b1, 1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 6'h00, 1'b1, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 6'h00, 1'b1, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 6'h08, 1'b1, 2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 6'h08, 1'b1, 2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 6'h00, 1'b1, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 6'h00, 1'b1, 2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 6'h01, 1'b0, 0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 6'h01, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 6'h02, 1'b1, 1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 6'h10, 1'b0, 0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 6'h02, 1'b1, 1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 6'h00, 1'b1, 1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 6'h08, 1'b1, 2, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 6'h02, 1'b1, 1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 6'h00, 1'b0, 0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 6'h00, 1'b0, 0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b1; btn = 6'h00;
        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].r, tbl[i].e, tbl[i].b);
            expect4($sformatf("table[%0d]", i), 0, tbl[i].o, tbl[i].s, tbl[i].dn, tbl[i].f);
        end

        // Window edge: 8-cycle gap accepted, 9-cycle gap times out.
        go_idle();
        tick(1'b0, 1'b1, 6'h02);
        repeat (7) tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h08);
        expect4("win_edge_accept", 0, 1'b1, 2, 1'b0, 1'b0);
        go_idle();
        tick(1'b0, 1'b1, 6'h02);
        repeat (7) tick(1'b0, 1'b1, 6'h00);
        expect4("win_last_cycle", 0, 1'b1, 1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h00);
        expect4("win_timeout", 0, 1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 6'h08);
        expect4("late_press_ignored", 0, 1'b0, 0, 1'b0, 1'b0);

        // Repeated step-0 press restarts the combo.
        go_idle();
        tick(1'b0, 1'b1, 6'h02);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h02);
        expect4("restart_fail", 0, 1'b1, 1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h08);
        expect4("restart_step2", 0, 1'b1, 2, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h01);
        expect4("restart_done", 0, 1'b0, 0, 1'b1, 1'b0);

        // Simultaneous buttons.
        go_idle();
        tick(1'b0, 1'b1, 6'h02);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h28);
        expect4("multi_armed", 0, 1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b1, 6'h06);
        expect4("multi_idle", 0, 1'b0, 0, 1'b0, 1'b0);

        // Buttons held through reset or enable rise never count.
        tick(1'b1, 1'b1, 6'h02);
        tick(1'b0, 1'b1, 6'h02);
        tick(1'b0, 1'b1, 6'h02);
        expect4("held_thru_rst", 0, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h00);
        tick(1'b0, 1'b0, 6'h02);
        tick(1'b0, 1'b1, 6'h02);
        expect4("held_thru_enable", 0, 1'b0, 0, 1'b0, 1'b0);

        // Single-step combo and repeated-button combo.
        go_idle();
        tick(1'b0, 1'b1, 6'h04);
        expect4("len1_done", 1, 1'b0, 0, 1'b1, 1'b0);
        expect4("rep_step1", 2, 1'b1, 1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h00);
        expect4("len1_pulse_end", 1, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h04);
        expect4("rep_step2", 2, 1'b1, 2, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 6'h20);
        expect4("rep_done", 2, 1'b0, 0, 1'b1, 1'b0);

        // Randomised traffic, biased toward the next expected button of dut0.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      b = 6'h00;
            else if (sel < 7) b = 6'(1) << m_seq[0][m_count[0]];
            else if (sel < 9) b = 6'(1) << $urandom_range(0, 5);
            else              b = 6'($urandom);
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0), b);
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(6, 10)) tick(1'b0, 1'b1, 6'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/combo_sequence_detector.md
Name: combo_sequence_detector

Overview:
Parametrised successor to the single-button combo window. It watches NUM_INPUTS player buttons and recognises one fixed ordered sequence of SEQ_LEN presses, each press arriving within WINDOW_CYCLES of the previous one. On completion it pulses combo_done; a wrong press or a timeout pulses combo_fail. One instance sits per player per combo, between input debouncing and the move/attack FSM.

Parameters:
NUM_INPUTS, 6, number of button lines.
IDX_W, 3, bits per button index; 2**IDX_W >= NUM_INPUTS.
SEQ_LEN, 3, number of steps in the combo; range 1..8.
COMBO_SEQ, {3'd0,3'd3,3'd1}, flattened SEQ_LEN*IDX_W vector of button indices; step k is bits [k*IDX_W +: IDX_W], and step 0 is pressed first.
WINDOW_CYCLES, 25000000, maximum number of cycles allowed from one accepted press to the next; must be >= 1.
CNT_W, 25, timer width; must satisfy 2**CNT_W > WINDOW_CYCLES.
STEP_W, 3, width of the step output; 2**STEP_W >= SEQ_LEN.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
enable  in  1  when low, the FSM is forced to IDLE and no pulses are generated.
btn  in  NUM_INPUTS  debounced, level-high button states, synchronous to clk.
window_open  out  1  high while a combo is in progress (ARMED).
step  out  STEP_W  number of steps matched so far; 0 in IDLE.
combo_done  out  1  one-cycle pulse when the full sequence is matched.
combo_fail  out  1  one-cycle pulse when an in-progress combo is aborted (wrong press or timeout).

Behaviour:
- Edge detection: btn_q is a register that captures btn every cycle. The press vector is edge = btn & ~btn_q. Only rising edges count. A held button is never a repeated press; to use the same button for two consecutive steps, the player must release and press it again.
- Matching: a cycle "matches step k" when edge is one-hot and its set bit equals COMBO_SEQ step k. Any other nonzero edge is a "wrong press", including the expected button pressed together with another button.
- States: IDLE and ARMED. All outputs are registered and change on the clk edge where the condition is sampled.
- IDLE, edge matches step 0:
  - if SEQ_LEN==1: pulse combo_done and stay in IDLE;
  - otherwise: go to ARMED with step=1 and timer=WINDOW_CYCLES-1.
- IDLE, any other edge: ignored; no fail pulse.
- ARMED, edge matches step `step`:
  - if this is the final step: pulse combo_done, go to IDLE, step=0;
  - otherwise: step+1 and reload timer=WINDOW_CYCLES-1.
- ARMED, wrong press: pulse combo_fail. If the edge matches step 0, restart (step=1, timer reloaded, remain ARMED); otherwise go to IDLE with step=0.
- ARMED, edge==0: if timer==0, pulse combo_fail and go to IDLE; otherwise decrement timer. Net effect: the next press must be sampled within WINDOW_CYCLES clock edges after the accepted press.
- Simultaneous events:
  - a press arriving on the same cycle that timer==0 is evaluated as a press; the press wins over the timeout.
  - combo_done and combo_fail are never high in the same cycle.
- enable low: state=IDLE, step=0, timer=0, no pulses. btn_q keeps tracking btn, so a button held while enable rises does not produce a press.
- Reset, including mid-combo: state=IDLE, step=0, timer=0, window_open=0, combo_done=0, combo_fail=0, btn_q=all ones. Buttons held through reset therefore never produce a press; they must be released and pressed again.
- Timer never wraps: it is reloaded only on an accepted step and saturates at 0.
- Latency: one clock from the sampled edge to the output update. No hidden pipeline.

Test Plan:
(All scenarios use WINDOW_CYCLES=8 and COMBO_SEQ steps 1,3,0 unless stated.)
1. Nominal combo: press btn1, then btn3 4 cycles later, then btn0 4 cycles after that, each press held 2 cycles -> step goes 1,2,0; window_open is high from the cycle after the btn1 edge until the btn0 edge; a single combo_done pulse is sampled on the btn0 edge; combo_fail stays 0 throughout.
2. Window limits: btn1 then btn3 exactly 8 cycles later -> accepted (step=2). Repeat with a 9-cycle gap -> combo_fail pulses 8 cycles after the btn1 edge, window_open drops, and the late btn3 press is ignored (no second fail).
3. Wrong press and restart: btn1, btn4 -> combo_fail, back to IDLE, step=0. Then btn1, btn1 (release between presses) -> combo_fail pulses on the second btn1 press and the FSM stays ARMED with step=1; a following btn3, btn0 completes the combo with a combo_done pulse.
4. Simultaneous buttons: in ARMED with step=1, btn3 and btn5 rise in the same cycle -> combo_fail, IDLE. From IDLE, btn1 and btn2 rise together -> ignored, no pulses.
5. Held button and reset: hold btn1 across a rst pulse and afterwards -> no press is detected. Mid-combo at step=2, assert rst -> next cycle step=0, window_open=0, no pulses. Lower enable mid-combo -> same result.
6. SEQ_LEN=1 with COMBO_SEQ=2, plus repeated-button sequence: btn2 press -> combo_done pulse and window_open stays 0. With COMBO_SEQ steps 2,2,5: press, release, press btn2, then press btn5 -> combo_done pulses.
